// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the asynchronous instruction RAM
// and buffers returned words in a 2-entry queue feeding decode over valid/ready.
module fetch_unit #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_dout,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  input  logic                  halt,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [31:0]           instr_pc,
  output logic [31:0]           pc,
  output logic                  misaligned
);

  typedef enum logic {RUN, HALTED} state_e;

  state_e                state_q, state_d;
  logic [31:0]           pc_q, pc_d;
  logic [DATA_WIDTH-1:0] qi_q [2];
  logic [DATA_WIDTH-1:0] qi_d [2];
  logic [31:0]           qp_q [2];
  logic [31:0]           qp_d [2];
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  misaligned_q, misaligned_d;
  logic                  fetch_en;
  logic                  deq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // halt wins over a simultaneous redirect; only a redirect without halt restarts fetching
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt) state_d = HALTED;
      HALTED:  if (redirect_valid && !halt) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    deq      = (count_q != 2'd0) & instr_ready;
    fetch_en = (state_q == RUN) & ~redirect_valid & ((count_q < 2'd2) | deq);
  end

  always_comb begin
    pc_d         = pc_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    qi_d         = qi_q;
    qp_d         = qp_q;
    misaligned_d = misaligned_q | (redirect_valid & (redirect_pc[1:0] != 2'b00));
    if (redirect_valid) begin
      // the flush discards whatever decode might have taken this cycle
      pc_d     = {redirect_pc[31:2], 2'b00};
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (fetch_en) begin
        qi_d[wr_ptr_q] = imem_dout;
        qp_d[wr_ptr_q] = pc_q;
        wr_ptr_d       = ~wr_ptr_q;
        pc_d           = pc_q + 32'd4;
      end
      if (deq) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, fetch_en} - {1'b0, deq};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      count_q      <= 2'd0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      qi_q[0]      <= '0;
      qi_q[1]      <= '0;
      qp_q[0]      <= '0;
      qp_q[1]      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      qi_q         <= qi_d;
      qp_q         <= qp_d;
      misaligned_q <= misaligned_d;
    end
  end

  // head outputs come only from registers, so instr_ready never reaches them combinationally
  assign imem_addr   = pc_q[ADDR_WIDTH+1:2];
  assign instr_valid = (count_q != 2'd0);
  assign instr       = qi_q[rd_ptr_q];
  assign instr_pc    = qp_q[rd_ptr_q];
  assign pc          = pc_q;
  assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// compared against a queue-based behavioural model of the fetch stage.
module tb_fetch_unit;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_dout;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          halt;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr;
  logic [31:0]   instr_pc;
  logic [31:0]   pc;
  logic          misaligned;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] ram [2**AW];

  fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_dout(imem_dout),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .pc(pc), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  assign imem_dout = ram[imem_addr];

  // behavioural model: queue of fetched {instruction, pc} pairs, capacity two
  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } entry_t;

  entry_t      mq[$];
  logic [31:0] m_pc;
  bit          m_halted;
  bit          m_mis;

  function automatic logic [31:0] ram_word(input logic [31:0] byte_pc);
    return 32'h1000_0000 + ((byte_pc >> 2) % (2**AW));
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc     = RPC;
    m_halted = 0;
    m_mis    = 0;
  endtask

  task automatic model_step();
    bit take;
    bit grab;
    bit was_halted;
    take       = (mq.size() != 0) && instr_ready;
    grab       = !m_halted && !redirect_valid && (mq.size() < 2 || take);
    was_halted = m_halted;
    if (redirect_valid) begin
      mq.delete();
      m_pc = redirect_pc & 32'hFFFF_FFFC;
      if (redirect_pc % 4 != 0) m_mis = 1;
    end else begin
      if (take) void'(mq.pop_front());
      if (grab) begin
        mq.push_back('{ins: ram_word(m_pc), pc: m_pc});
        m_pc = m_pc + 4;
      end
    end
    if (!was_halted && halt) m_halted = 1;
    else if (was_halted && redirect_valid && !halt) m_halted = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt           = 1'b0;
    instr_ready    = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt           = 1'b0;
    instr_ready    = 1'b1;
    model_reset();
    #2;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", instr_valid); end
    total++; if (pc !== RPC) begin bad++; $display("[TB] FAIL reset_pc got=%h want=%h", pc, RPC); end
    total++; if (imem_addr !== RPC[AW+1:2]) begin bad++; $display("[TB] FAIL reset_addr got=%h want=%h", imem_addr, RPC[AW+1:2]); end
    total++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin bad++; $display("[TB] FAIL reset_head got=%h/%h want=0/0", instr, instr_pc); end
    total++; if (misaligned !== 1'b0) begin bad++; $display("[TB] FAIL reset_mis got=%b want=0", misaligned); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_stream();
    tick();
    total++; if (instr_valid !== 1'b1 || instr !== 32'h1000_0000 || instr_pc !== 32'h0) begin
      bad++; $display("[TB] FAIL stream_first got=%b %h %h want=1 10000000 0", instr_valid, instr, instr_pc);
    end
    for (int i = 1; i < 4; i++) begin
      tick();
      total++; if (instr_valid !== 1'b1 || instr_pc !== 32'(i * 4) || instr !== 32'h1000_0000 + 32'(i)) begin
        bad++; $display("[TB] FAIL stream_seq%0d got=%b %h %h want=1 %h %h", i, instr_valid, instr, instr_pc, 32'h1000_0000 + 32'(i), i * 4);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    total++; if (pc !== 32'h8) begin bad++; $display("[TB] FAIL bp_pc got=%h want=8", pc); end
    total++; if (instr_valid !== 1'b1 || instr !== 32'h1000_0000 || instr_pc !== 32'h0) begin
      bad++; $display("[TB] FAIL bp_hold got=%b %h %h want=1 10000000 0", instr_valid, instr, instr_pc);
    end
    instr_ready = 1'b1;
    for (int i = 1; i < 3; i++) begin
      tick();
      total++; if (instr_valid !== 1'b1 || instr_pc !== 32'(i * 4)) begin
        bad++; $display("[TB] FAIL bp_drain%0d got=%b %h want=1 %h", i, instr_valid, instr_pc, i * 4);
      end
    end
  endtask

  task automatic test_redirect();
    instr_ready = 1'b0;
    tick();
    total++; if (instr_valid !== 1'b1) begin bad++; $display("[TB] FAIL redir_full got=%b want=1", instr_valid); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    total++; if (instr_valid !== 1'b0 || pc !== 32'h40) begin
      bad++; $display("[TB] FAIL redir_flush got=%b %h want=0 40", instr_valid, pc);
    end
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    tick();
    total++; if (instr_valid !== 1'b1 || instr !== 32'h1000_0010 || instr_pc !== 32'h40) begin
      bad++; $display("[TB] FAIL redir_target got=%b %h %h want=1 10000010 40", instr_valid, instr, instr_pc);
    end
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    tick();
    total++; if (pc !== 32'h40 || misaligned !== 1'b1) begin
      bad++; $display("[TB] FAIL mis_set got=%h %b want=40 1", pc, misaligned);
    end
    redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    tick();
    total++; if (pc !== 32'h84 || misaligned !== 1'b1) begin
      bad++; $display("[TB] FAIL mis_sticky got=%h %b want=84 1", pc, misaligned);
    end
    do_reset();
    total++; if (misaligned !== 1'b0) begin bad++; $display("[TB] FAIL mis_clear got=%b want=0", misaligned); end
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    total++; if (pc !== 32'h10) begin bad++; $display("[TB] FAIL halt_pc got=%h want=10", pc); end
    for (int i = 0; i < 3; i++) tick();
    total++; if (pc !== 32'h10 || instr_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL halt_drain got=%h %b want=10 0", pc, instr_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    tick();
    redirect_valid = 1'b0;
    tick();
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || pc !== 32'h4) begin
      bad++; $display("[TB] FAIL halt_resume got=%b %h %h want=1 0 4", instr_valid, instr_pc, pc);
    end
    halt           = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    tick();
    halt           = 1'b0;
    redirect_valid = 1'b0;
    total++; if (pc !== 32'h20 || instr_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL halt_redir got=%h %b want=20 0", pc, instr_valid);
    end
    tick();
    tick();
    total++; if (pc !== 32'h20 || instr_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL halt_stay got=%h %b want=20 0", pc, instr_valid);
    end
  endtask

  task automatic test_wrap_async_reset();
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3FC;
    tick();
    redirect_valid = 1'b0;
    total++; if (imem_addr !== 8'hFF) begin bad++; $display("[TB] FAIL wrap_hi got=%h want=ff", imem_addr); end
    tick();
    total++; if (pc !== 32'h400 || imem_addr !== 8'h00) begin
      bad++; $display("[TB] FAIL wrap_lo got=%h %h want=400 00", pc, imem_addr);
    end
    total++; if (instr !== 32'h1000_00FF || instr_pc !== 32'h3FC) begin
      bad++; $display("[TB] FAIL wrap_head got=%h %h want=100000ff 3fc", instr, instr_pc);
    end
    tick();
    rst = 1'b1;
    #1;
    total++; if (instr_valid !== 1'b0 || pc !== RPC) begin
      bad++; $display("[TB] FAIL async_rst got=%b %h want=0 %h", instr_valid, pc, RPC);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      instr_ready    = ($urandom % 4) != 0;
      redirect_valid = ($urandom % 10) == 0;
      redirect_pc    = (($urandom % 8) == 0) ? $urandom : ($urandom & 32'h0000_03FC);
      halt           = ($urandom % 16) == 0;
      tick();
      total++; if (instr_valid !== (mq.size() != 0)) begin
        bad++; $display("[TB] FAIL rnd_valid cyc=%0d got=%b want=%0d", i, instr_valid, mq.size() != 0);
      end
      total++; if (pc !== m_pc) begin bad++; $display("[TB] FAIL rnd_pc cyc=%0d got=%h want=%h", i, pc, m_pc); end
      total++; if (misaligned !== m_mis) begin bad++; $display("[TB] FAIL rnd_mis cyc=%0d got=%b want=%b", i, misaligned, m_mis); end
      if (mq.size() != 0) begin
        total++; if (instr !== mq[0].ins || instr_pc !== mq[0].pc) begin
          bad++; $display("[TB] FAIL rnd_head cyc=%0d got=%h %h want=%h %h", i, instr, instr_pc, mq[0].ins, mq[0].pc);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) ram[i] = 32'h1000_0000 + 32'(i);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misaligned();
    test_halt();
    test_wrap_async_reset();
    do_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the asynchronous instruction RAM.
- Owns the program counter and drives the RAM word address.
- Captures the returned instruction into a 2-entry queue and hands {instruction, PC} to decode over a valid/ready handshake.
- Supports control-flow redirects (branch/jump) and a halt/restart state machine.

Parameters:
ADDR_WIDTH, 8, instruction RAM word-address width (2**ADDR_WIDTH words)
DATA_WIDTH, 32, instruction width
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
imem_addr  output  ADDR_WIDTH  RAM word address = pc[ADDR_WIDTH+1:2], combinational
imem_dout  input  DATA_WIDTH  RAM read data, valid in the same cycle as imem_addr
redirect_valid  input  1  load redirect_pc this cycle
redirect_pc  input  32  redirect target byte address
halt  input  1  request to stop fetching
instr_valid  output  1  queue head valid
instr_ready  input  1  decode accepts head
instr  output  DATA_WIDTH  queue head instruction
instr_pc  output  32  byte PC of queue head
pc  output  32  current fetch PC
misaligned  output  1  sticky flag: a redirect target had bits [1:0] != 0

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values:
  - pc = RESET_PC; state = RUN.
  - Queue count = 0; read/write pointers = 0; storage = 0.
  - instr_valid = 0, instr = 0, instr_pc = 0, misaligned = 0.
  - imem_addr = RESET_PC[ADDR_WIDTH+1:2].
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.
- Queue:
  - 2-entry FIFO of {instr, pc}. instr_valid = (count != 0); instr/instr_pc are driven from storage at the read pointer.
  - When empty, the head outputs show stale storage; decode ignores them.
  - deq = instr_valid & instr_ready.
- Fetch: fetch_en = (state == RUN) & ~redirect_valid & (count < 2 | deq).
  - On fetch_en: push {imem_dout, pc}, and pc <= pc + 4.
- Latency: the instruction at PC X is on instr one cycle after pc == X, provided it was fetched.
- Throughput: one instruction per cycle while instr_ready = 1.
- Simultaneous push and pop with count = 2 is legal; count stays 2.
- Redirect (highest priority), in the same cycle:
  - Queue is flushed (count <= 0, pointers reset).
  - pc <= {redirect_pc[31:2], 2'b00}; no push.
  - Any deq that cycle is irrelevant, since the entry is discarded.
  - instr_valid is 0 in the following cycle.
  - If redirect_pc[1:0] != 0, misaligned <= 1 and stays set until rst.
- State machine:
  - RUN -> HALTED when halt = 1.
  - HALTED -> RUN when redirect_valid = 1 and halt = 0.
  - halt and redirect_valid together: go to or stay in HALTED, the pc load still occurs, and the queue is flushed.
  - In HALTED: no fetches, pc frozen, and decode may still drain the queue.
- Arithmetic: pc + 4 wraps modulo 2**32. imem_addr wraps naturally at 2**ADDR_WIDTH words; no out-of-range detection.
- No combinational path from instr_ready to instr_valid, instr, or instr_pc.

Test Plan:
- RAM word i = 0x1000_0000 + i, instr_ready = 1, release rst → cycle 1: instr_valid = 1, instr = 0x1000_0000, instr_pc = 0; then instr_pc 4, 8, 12 on consecutive cycles.
- instr_ready = 0 from reset → two fetches, pc stops at 0x8, instr holds 0x1000_0000; raise instr_ready → outputs 0x0, 0x4, 0x8 in order, no gaps or duplicates.
- Queue full, redirect_valid = 1 with redirect_pc = 0x40 → next cycle instr_valid = 0 and pc = 0x40; following cycle instr = 0x1000_0010, instr_pc = 0x40.
- redirect_pc = 0x43 → pc = 0x40, misaligned = 1 and held across later redirects until rst pulse.
- halt = 1 for one cycle → pc frozen, queue drains to instr_valid = 0; redirect to 0x0 → fetch resumes at instr_pc = 0; halt together with redirect to 0x20 → pc = 0x20, state stays HALTED.
- ADDR_WIDTH = 8, redirect to 0x3FC → imem_addr 0xFF, then 0x00 at pc 0x400; assert rst asynchronously mid-stream → instr_valid = 0 and pc = RESET_PC before the next edge.
